// File: rtl/fighter_pkg.sv
// Shared types for the fighter stat block: FSM states and the per-class attribute table.
package fighter_pkg;

  typedef enum logic [1:0] {StInit, StAlive, StInvuln, StKo} fighter_state_e;

  typedef struct packed {
    logic [8:0] max_hp;
    logic [2:0] speed;
    logic [2:0] dodge;
    logic [4:0] max_sp;
    logic [2:0] color;
  } class_rec_t;

  // Entry 3 covers every class code from 3 to 7.
  localparam class_rec_t ClassTable [4] = '{
    '{9'd175, 3'd4, 3'd5, 5'd8,  3'b110},
    '{9'd150, 3'd6, 3'd7, 5'd10, 3'b011},
    '{9'd200, 3'd2, 3'd5, 5'd10, 3'b101},
    '{9'd150, 3'd7, 3'd7, 5'd8,  3'b010}
  };

  function automatic class_rec_t class_rec(input logic [2:0] cls);
    return (cls > 3'd2) ? ClassTable[3] : ClassTable[cls[1:0]];
  endfunction

  function automatic logic [8:0] class_max_hp(input logic [2:0] cls);
    class_rec_t rec;
    rec = class_rec(cls);
    return rec.max_hp;
  endfunction

  function automatic logic [4:0] class_max_sp(input logic [2:0] cls);
    class_rec_t rec;
    rec = class_rec(cls);
    return rec.max_sp;
  endfunction

endpackage

// File: rtl/sat_meter.sv
// Registered meter: adds a signed delta and clamps the result to [0, max_val], or loads a value.
module sat_meter #(
  parameter int unsigned W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                upd,
  input  logic                load,
  input  logic [W-1:0]        load_val,
  input  logic signed [W+1:0] delta,
  input  logic [W-1:0]        max_val,
  output logic [W-1:0]        next_val,
  output logic [W-1:0]        value
);

  logic signed [W+1:0] sum;

  always_comb begin
    sum = $signed({2'b00, value}) + delta;
    if (sum < 0) begin
      next_val = '0;
    end else if (sum > $signed({2'b00, max_val})) begin
      next_val = max_val;
    end else begin
      next_val = sum[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (upd) begin
      value <= load ? load_val : next_val;
    end
  end

endmodule

// File: rtl/fighter_stats.sv
// Per-fighter health/special meters with invulnerability frames, regen and knock-out.
module fighter_stats
  import fighter_pkg::*;
#(
  parameter int unsigned HP_W         = 9,
  parameter int unsigned SP_W         = 5,
  parameter int unsigned DMG_W        = 6,
  parameter int unsigned COST_W       = 3,
  parameter int unsigned INVULN_CYC   = 8,
  parameter int unsigned REGEN_PERIOD = 16
) (
  input  logic              update,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        char_sel,
  input  logic              dmg_valid,
  input  logic [DMG_W-1:0]  dmg,
  input  logic              heal_valid,
  input  logic [DMG_W-1:0]  heal,
  input  logic              sp_req,
  input  logic [COST_W-1:0] sp_cost,
  output logic              sp_grant,
  output logic              sp_deny,
  output logic [HP_W-1:0]   health,
  output logic [SP_W-1:0]   special,
  output logic [2:0]        speed,
  output logic [2:0]        dodge,
  output logic [2:0]        color,
  output logic              invuln,
  output logic              ko
);

  localparam int unsigned InvW = $clog2(INVULN_CYC + 1);
  localparam int unsigned RegW = $clog2(REGEN_PERIOD);

  fighter_state_e    state_q, state_d;
  logic [2:0]        cls_q, cls_d;
  logic [InvW-1:0]   inv_cnt_q, inv_cnt_d;
  logic [RegW-1:0]   regen_cnt_q, regen_cnt_d;
  logic              grant_q, deny_q;

  class_rec_t        cur_rec;
  logic              active, regen_tick, grant_req, deny_req, meter_upd, load;
  logic [DMG_W-1:0]  dmg_eff, heal_eff;
  logic [COST_W-1:0] cost_eff;
  logic signed [HP_W+1:0] hp_delta;
  logic signed [SP_W+1:0] sp_delta;
  logic [HP_W-1:0]   hp_next;
  logic [SP_W-1:0]   sp_next;

  assign cur_rec    = class_rec(cls_q);
  assign active     = (state_q == StAlive) || (state_q == StInvuln);
  assign regen_tick = active && (regen_cnt_q == RegW'(REGEN_PERIOD - 1));
  assign grant_req  = active && sp_req && (special >= SP_W'(sp_cost));
  assign deny_req   = active && sp_req && !grant_req;
  assign load       = (state_q == StInit);
  assign meter_upd  = en && (load || active);

  // Damage only bites while fully vulnerable; healing works in either live state.
  assign dmg_eff  = (dmg_valid && state_q == StAlive) ? dmg : '0;
  assign heal_eff = heal_valid ? heal : '0;
  assign cost_eff = grant_req ? sp_cost : '0;
  assign hp_delta = (HP_W+2)'(heal_eff) - (HP_W+2)'(dmg_eff);
  assign sp_delta = (SP_W+2)'(regen_tick) - (SP_W+2)'(cost_eff);

  sat_meter #(.W(HP_W)) u_health (
    .clk      (update),
    .rst      (rst),
    .upd      (meter_upd),
    .load     (load),
    .load_val (HP_W'(class_max_hp(char_sel))),
    .delta    (hp_delta),
    .max_val  (HP_W'(cur_rec.max_hp)),
    .next_val (hp_next),
    .value    (health)
  );

  sat_meter #(.W(SP_W)) u_special (
    .clk      (update),
    .rst      (rst),
    .upd      (meter_upd),
    .load     (load),
    .load_val (SP_W'(class_max_sp(char_sel))),
    .delta    (sp_delta),
    .max_val  (SP_W'(cur_rec.max_sp)),
    .next_val (sp_next),
    .value    (special)
  );

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    inv_cnt_d   = inv_cnt_q;
    regen_cnt_d = regen_cnt_q;
    if (en) begin
      unique case (state_q)
        StInit: begin
          cls_d   = char_sel;
          state_d = StAlive;
        end
        StAlive, StInvuln: begin
          regen_cnt_d = regen_tick ? '0 : regen_cnt_q + 1'b1;
          if (hp_next == '0) begin
            state_d = StKo;
          end else if (state_q == StAlive && dmg_valid && dmg != '0) begin
            state_d   = StInvuln;
            inv_cnt_d = InvW'(INVULN_CYC);
          end else if (state_q == StInvuln) begin
            inv_cnt_d = inv_cnt_q - 1'b1;
            if (inv_cnt_q == InvW'(1)) state_d = StAlive;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge update or negedge rst) begin
    if (!rst) begin
      state_q     <= StInit;
      cls_q       <= '0;
      inv_cnt_q   <= '0;
      regen_cnt_q <= '0;
      grant_q     <= 1'b0;
      deny_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      inv_cnt_q   <= inv_cnt_d;
      regen_cnt_q <= regen_cnt_d;
      grant_q     <= en && grant_req;
      deny_q      <= en && deny_req;
    end
  end

  assign sp_grant = grant_q;
  assign sp_deny  = deny_q;
  assign speed    = cur_rec.speed;
  assign dodge    = cur_rec.dodge;
  assign color    = cur_rec.color;
  assign invuln   = (state_q == StInvuln);
  assign ko       = (state_q == StKo);

endmodule

// File: tb/tb_fighter_stats.sv
// Directed self-checking bench for fighter_stats with hand-computed expectations.
module tb_fighter_stats;

  logic       update = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [2:0] char_sel = '0;
  logic       dmg_valid = 1'b0;
  logic [5:0] dmg = '0;
  logic       heal_valid = 1'b0;
  logic [5:0] heal = '0;
  logic       sp_req = 1'b0;
  logic [2:0] sp_cost = '0;
  logic       sp_grant, sp_deny, invuln, ko;
  logic [8:0] health;
  logic [4:0] special;
  logic [2:0] speed, dodge, color;

  int checks = 0;
  int failures = 0;

  fighter_stats dut (
    .update     (update),
    .rst        (rst),
    .en         (en),
    .char_sel   (char_sel),
    .dmg_valid  (dmg_valid),
    .dmg        (dmg),
    .heal_valid (heal_valid),
    .heal       (heal),
    .sp_req     (sp_req),
    .sp_cost    (sp_cost),
    .sp_grant   (sp_grant),
    .sp_deny    (sp_deny),
    .health     (health),
    .special    (special),
    .speed      (speed),
    .dodge      (dodge),
    .color      (color),
    .invuln     (invuln),
    .ko         (ko)
  );

  always #5 update = ~update;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge update);
      #1;
    end
  endtask

  task automatic idle();
    dmg_valid = 1'b0; dmg = '0; heal_valid = 1'b0; heal = '0; sp_req = 1'b0; sp_cost = '0;
  endtask

  task automatic do_reset(input logic [2:0] cls);
    rst = 1'b0;
    idle();
    en = 1'b1;
    char_sel = cls;
    #2;
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    // Reset values, then class 2 load
    en = 1'b1; char_sel = 3'd2;
    #12;
    chk("rst_health", health, 0);
    chk("rst_special", special, 0);
    chk("rst_ko", ko, 0);
    chk("rst_invuln", invuln, 0);
    chk("rst_speed", speed, 4);
    chk("rst_color", color, 3'b110);
    chk("rst_grant", sp_grant, 0);
    rst = 1'b1;
    step(1);
    chk("c2_health", health, 200);
    chk("c2_special", special, 10);
    chk("c2_speed", speed, 2);
    chk("c2_dodge", dodge, 5);
    chk("c2_color", color, 3'b101);
    chk("c2_ko", ko, 0);

    // Hit, invulnerability window, special grant/deny, heal clamp, regen tick
    do_reset(3'd0);
    chk("c0_health", health, 175);
    chk("c0_special", special, 8);
    dmg_valid = 1'b1; dmg = 6'd30; step(1);
    chk("hit_health", health, 145);
    chk("hit_invuln", invuln, 1);
    dmg = 6'd20; step(1);
    chk("inv_dmg_ignored", health, 145);
    idle(); step(6);
    chk("inv_last_cycle", invuln, 1);
    step(1);
    chk("inv_ended", invuln, 0);
    dmg_valid = 1'b1; dmg = 6'd10; step(1);
    chk("hit2_health", health, 135);
    idle(); sp_req = 1'b1; sp_cost = 3'd5; step(1);
    chk("grant_special", special, 3);
    chk("grant_pulse", sp_grant, 1);
    chk("grant_nodeny", sp_deny, 0);
    step(1);
    chk("deny_special", special, 3);
    chk("deny_pulse", sp_deny, 1);
    chk("deny_nogrant", sp_grant, 0);
    idle(); heal_valid = 1'b1; heal = 6'd50; step(1);
    chk("heal_clamp", health, 175);
    chk("deny_dropped", sp_deny, 0);
    idle(); step(2);
    chk("pre_regen", special, 3);
    step(1);
    chk("regen_tick", special, 4);

    // Regen saturation, grant coinciding with regen tick
    do_reset(3'd0);
    step(15);
    chk("sat_pre", special, 8);
    step(1);
    chk("sat_tick", special, 8);
    step(15);
    sp_req = 1'b1; sp_cost = 3'd2; step(1);
    chk("grant_on_tick", special, 7);
    chk("grant_on_tick_pulse", sp_grant, 1);

    // Knock-out with simultaneous heal; KO ignores everything
    do_reset(3'd0);
    dmg_valid = 1'b1; dmg = 6'd63; step(1);
    chk("ko_h1", health, 112);
    idle(); step(8);
    chk("ko_inv_off", invuln, 0);
    dmg_valid = 1'b1; dmg = 6'd63; step(1);
    chk("ko_h2", health, 49);
    idle(); step(8);
    dmg_valid = 1'b1; dmg = 6'd9; step(1);
    chk("ko_h3", health, 40);
    idle(); step(8);
    dmg_valid = 1'b1; dmg = 6'd63; heal_valid = 1'b1; heal = 6'd10; step(1);
    chk("ko_health", health, 0);
    chk("ko_flag", ko, 1);
    chk("ko_noinv", invuln, 0);
    idle(); heal_valid = 1'b1; heal = 6'd20; sp_req = 1'b1; sp_cost = 3'd1; step(1);
    chk("ko_heal_ignored", health, 0);
    chk("ko_sp_frozen", special, 8);
    chk("ko_no_grant", sp_grant, 0);
    chk("ko_no_deny", sp_deny, 0);
    idle(); step(20);
    chk("ko_sticky", ko, 1);
    chk("ko_sp_still", special, 8);

    // Enable freeze mid-invulnerability, then async reset mid-invulnerability
    do_reset(3'd0);
    dmg_valid = 1'b1; dmg = 6'd30; step(1);
    idle(); step(2);
    en = 1'b0; dmg_valid = 1'b1; dmg = 6'd5; heal_valid = 1'b1; heal = 6'd3;
    sp_req = 1'b1; sp_cost = 3'd1;
    step(20);
    chk("frz_health", health, 145);
    chk("frz_special", special, 8);
    chk("frz_invuln", invuln, 1);
    chk("frz_no_grant", sp_grant, 0);
    en = 1'b1; idle(); step(5);
    chk("frz_resume_inv", invuln, 1);
    chk("frz_resume_hp", health, 145);
    rst = 1'b0; #1;
    chk("arst_health", health, 0);
    chk("arst_special", special, 0);
    chk("arst_invuln", invuln, 0);
    chk("arst_speed", speed, 4);
    char_sel = 3'd1; #1; rst = 1'b1;
    step(1);
    chk("c1_health", health, 150);
    chk("c1_special", special, 10);
    chk("c1_speed", speed, 6);
    chk("c1_dodge", dodge, 7);
    chk("c1_color", color, 3'b011);

    // Upper class codes and zero-cost special
    do_reset(3'd5);
    chk("c5_health", health, 150);
    chk("c5_special", special, 8);
    chk("c5_speed", speed, 7);
    chk("c5_color", color, 3'b010);
    sp_req = 1'b1; sp_cost = 3'd0; step(1);
    chk("cost0_grant", sp_grant, 1);
    chk("cost0_special", special, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
